pwm_decoder: RTL



---
 rtl/pwm_decoder.sv | 116 +++++++++++
 1 files changed

// File: rtl/pwm_decoder.sv
// PWM stream decoder: recovers the W-bit control word from a 2^W-clock PWM frame
// and reports stream health (steady level, multiple rising edges per frame).
module pwm_decoder #(
  parameter int unsigned W = 10
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         pwm_in,
  output logic [W-1:0] duty_word,
  output logic         duty_valid,
  output logic         steady_low,
  output logic         steady_high,
  output logic         edge_err,
  output logic         locked
);

  typedef enum logic {ACQ, RUN} state_t;

  state_t       state, state_next;
  logic         sync1, pwm_s, pwm_d;
  logic         rise, frame_end, publish, align;
  logic [W-1:0] win_cnt;
  logic [W:0]   high_acc, acc_f;
  logic [1:0]   rise_cnt, rises_f;
  logic [2:0]   rise_sum;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1 <= 1'b0;
      pwm_s <= 1'b0;
      pwm_d <= 1'b0;
    end else begin
      sync1 <= pwm_in;
      pwm_s <= sync1;
      pwm_d <= pwm_s;
    end
  end

  assign rise      = pwm_s & ~pwm_d;
  assign frame_end = (win_cnt == '1);
  assign acc_f     = high_acc + {{W{1'b0}}, pwm_s};
  assign rise_sum  = {1'b0, rise_cnt} + {2'b00, rise};
  assign rises_f   = (rise_sum >= 3'd2) ? 2'd2 : rise_sum[1:0];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ACQ;
    else       state <= state_next;
  end

  // In ACQ a rise takes priority over a coincident frame end: realign, no publish.
  always_comb begin
    state_next = state;
    publish    = 1'b0;
    align      = 1'b0;
    case (state)
      ACQ: begin
        if (rise) begin
          align      = 1'b1;
          state_next = RUN;
        end else if (frame_end) begin
          publish = 1'b1;
        end
      end
      RUN: begin
        if (frame_end) begin
          publish = 1'b1;
          if (rises_f == 2'd2 || rises_f == 2'd0) state_next = ACQ;
        end
      end
      default: state_next = ACQ;
    endcase
  end

  assign locked = (state == RUN);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      win_cnt  <= '0;
      high_acc <= '0;
      rise_cnt <= '0;
    end else if (align) begin
      // The aligning rise sample itself is the first high sample of the frame.
      win_cnt  <= {{(W-1){1'b0}}, 1'b1};
      high_acc <= {{W{1'b0}}, 1'b1};
      rise_cnt <= 2'd1;
    end else begin
      win_cnt <= win_cnt + 1'b1;
      if (frame_end) begin
        high_acc <= '0;
        rise_cnt <= '0;
      end else begin
        high_acc <= acc_f;
        rise_cnt <= rises_f;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      duty_word   <= '0;
      duty_valid  <= 1'b0;
      steady_low  <= 1'b0;
      steady_high <= 1'b0;
      edge_err    <= 1'b0;
    end else begin
      duty_valid <= publish;
      if (publish) begin
        duty_word   <= acc_f[W] ? '1 : acc_f[W-1:0];
        steady_low  <= (acc_f == '0);
        steady_high <= acc_f[W];
        edge_err    <= (rises_f == 2'd2);
      end
    end
  end

endmodule
